// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK sequencing controller: command ops, FSM states
// and the per-bit {J,K} codes understood by jk_cell.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // {J,K} pairs
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_cell
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_CLR:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command-driven controller that loads, toggles or counts a register built
// only from JK cells; every change to q goes through per-bit J/K drive.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [3:0]       cmd_count,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output state_t           state
);

    // Handshake: a command is taken on the rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE and never during reset.

    state_t           state_next;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [3:0]       remaining;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] up_en;
    logic [WIDTH-1:0] dn_en;
    logic             accept;
    logic             step_cmd_in;
    logic             step_cmd_r;
    logic             wrap_next;

    assign cmd_ready   = (state == ST_IDLE) && !reset;
    assign busy        = ((state == ST_EXEC) || (state == ST_DONE)) && !reset;
    assign done        = (state == ST_DONE) && !reset;
    assign accept      = cmd_valid && cmd_ready;
    assign step_cmd_in = (op_t'(cmd_op) == OP_UP) || (op_t'(cmd_op) == OP_DOWN);
    assign step_cmd_r  = (op_r == OP_UP) || (op_r == OP_DOWN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_r      <= OP_LOAD;
            data_r    <= '0;
            remaining <= 4'd0;
            wrap      <= 1'b0;
        end else begin
            state <= state_next;
            wrap  <= wrap_next;
            if (accept) begin
                op_r      <= op_t'(cmd_op);
                data_r    <= cmd_data;
                remaining <= cmd_count;
            end else if ((state == ST_EXEC) && step_cmd_r) begin
                remaining <= remaining - 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    // Zero-step counts complete without touching q.
                    if (step_cmd_in && (cmd_count == 4'd0)) state_next = ST_DONE;
                    else                                     state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!step_cmd_r || (remaining == 4'd1)) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Ripple enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry_up;
        logic carry_dn;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        up_en    = '0;
        dn_en    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_en[i] = carry_up;
            dn_en[i] = carry_dn;
            carry_up = carry_up & q[i];
            carry_dn = carry_dn & qbar[i];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (state == ST_EXEC) begin
            case (op_r)
                OP_LOAD: begin
                    j = data_r;
                    k = ~data_r;
                end
                OP_TOGGLE: begin
                    j = data_r;
                    k = data_r;
                end
                OP_UP: begin
                    j = up_en;
                    k = up_en;
                end
                OP_DOWN: begin
                    j = dn_en;
                    k = dn_en;
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    assign wrap_next = (state == ST_EXEC) &&
                       (((op_r == OP_UP) && (&q)) || ((op_r == OP_DOWN) && (~|q)));

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i]),
            .qbar  (qbar[i])
        );
    end

endmodule
